// File: rtl/shifter32_pkg.sv
// Shared constants and shift-kind enumeration for the shifter32 barrel shifter.
package shifter32_pkg;

    localparam int WIDTH = 32;
    localparam int SW    = $clog2(WIDTH);

    typedef enum logic [2:0] {
        SH_LL,
        SH_RL,
        SH_RA,
        SH_ROTL,
        SH_ROTR
    } shift_kind_e;

endpackage

// File: rtl/shifter32_stage.sv
// One log-shifter layer: shifts by 2^K when en is set, otherwise passes d through.
module shifter32_stage
    import shifter32_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int          K     = 0,
    parameter shift_kind_e KIND  = SH_LL
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    localparam int N = 1 << K;

    logic [WIDTH-1:0] sh;

    // fill carries the original operand MSB so every arithmetic stage sign-extends from it
    always_comb begin
        sh = d;
        case (KIND)
            SH_LL:   sh = {d[WIDTH-N-1:0], {N{1'b0}}};
            SH_RL:   sh = {{N{1'b0}}, d[WIDTH-1:N]};
            SH_RA:   sh = {{N{fill}}, d[WIDTH-1:N]};
            SH_ROTL: sh = {d[WIDTH-N-1:0], d[WIDTH-1:WIDTH-N]};
            SH_ROTR: sh = {d[N-1:0], d[WIDTH-1:N]};
            default: sh = d;
        endcase
    end

    assign q = en ? sh : d;

endmodule

// File: rtl/shifter32.sv
// Barrel shifter: LL/RL/RA in parallel, combinational plus a registered copy with valid.
// Define SHIFTER32_ROTATE_EN to add rotate-left/right outputs.
module shifter32
    import shifter32_pkg::*;
#(
    parameter  int WIDTH = shifter32_pkg::WIDTH,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    s,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y_ll,
    output logic [WIDTH-1:0] y_rl,
    output logic [WIDTH-1:0] y_ra,
    output logic [WIDTH-1:0] q_ll,
    output logic [WIDTH-1:0] q_rl,
    output logic [WIDTH-1:0] q_ra,
`ifdef SHIFTER32_ROTATE_EN
    output logic [WIDTH-1:0] y_rotl,
    output logic [WIDTH-1:0] y_rotr,
    output logic [WIDTH-1:0] q_rotl,
    output logic [WIDTH-1:0] q_rotr,
`endif
    output logic             out_valid
);

`ifdef SHIFTER32_ROTATE_EN
    localparam int NK = 5;
`else
    localparam int NK = 3;
`endif

    logic [NK-1:0][WIDTH-1:0] res;
    logic [NK-1:0][WIDTH-1:0] res_q;
    logic                     vld_q;

    // Each kind gets its own SW-deep chain; stage k feeds stage k+1 by hierarchical name
    for (genvar j = 0; j < NK; j++) begin : g_kind
        for (genvar k = 0; k < SW; k++) begin : g_stage
            logic [WIDTH-1:0] d;
            logic [WIDTH-1:0] q;
            if (k == 0) begin : g_first
                assign d = a;
            end else begin : g_next
                assign d = g_stage[k-1].q;
            end
            shifter32_stage #(
                .WIDTH (WIDTH),
                .K     (k),
                .KIND  (shift_kind_e'(j))
            ) u_stage (
                .d    (d),
                .en   (s[k]),
                .fill (a[WIDTH-1]),
                .q    (q)
            );
        end
        assign res[j] = g_stage[SW-1].q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) res_q <= res;
        end
    end

    assign y_ll      = res[SH_LL];
    assign y_rl      = res[SH_RL];
    assign y_ra      = res[SH_RA];
    assign q_ll      = res_q[SH_LL];
    assign q_rl      = res_q[SH_RL];
    assign q_ra      = res_q[SH_RA];
    assign out_valid = vld_q;
`ifdef SHIFTER32_ROTATE_EN
    assign y_rotl    = res[SH_ROTL];
    assign y_rotr    = res[SH_ROTR];
    assign q_rotl    = res_q[SH_ROTL];
    assign q_rotr    = res_q[SH_ROTR];
`endif

endmodule

// File: tb/tb_shifter32.sv
// Self-checking bench for shifter32: directed literals plus a per-cycle model comparison.
module tb_shifter32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [4:0]  s;
    logic        in_valid;
    logic [31:0] y_ll, y_rl, y_ra, q_ll, q_rl, q_ra;
    logic        out_valid;
`ifdef SHIFTER32_ROTATE_EN
    logic [31:0] y_rotl, y_rotr, q_rotl, q_rotr;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    shifter32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .s         (s),
        .in_valid  (in_valid),
        .y_ll      (y_ll),
        .y_rl      (y_rl),
        .y_ra      (y_ra),
        .q_ll      (q_ll),
        .q_rl      (q_rl),
        .q_ra      (q_ra),
`ifdef SHIFTER32_ROTATE_EN
        .y_rotl    (y_rotl),
        .y_rotr    (y_rotr),
        .q_rotl    (q_rotl),
        .q_rotr    (q_rotr),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_ll(input logic [31:0] x, input int n);
        return x << n;
    endfunction
    function automatic logic [31:0] m_rl(input logic [31:0] x, input int n);
        return x >> n;
    endfunction
    function automatic logic [31:0] m_ra(input logic [31:0] x, input int n);
        return $signed(x) >>> n;
    endfunction
    function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction
    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference registered state, driven purely from the model functions
    logic [31:0] e_ll = '0, e_rl = '0, e_ra = '0, e_rotl = '0, e_rotr = '0;
    logic        e_ov = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ll = '0; e_rl = '0; e_ra = '0; e_rotl = '0; e_rotr = '0;
            e_ov = 1'b0;
        end else begin
            e_ov = in_valid;
            if (in_valid) begin
                e_ll   = m_ll(a, int'(s));
                e_rl   = m_rl(a, int'(s));
                e_ra   = m_ra(a, int'(s));
                e_rotl = m_rotl(a, int'(s));
                e_rotr = m_rotr(a, int'(s));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("y_ll", y_ll, m_ll(a, int'(s)));
            check("y_rl", y_rl, m_rl(a, int'(s)));
            check("y_ra", y_ra, m_ra(a, int'(s)));
            check("q_ll", q_ll, e_ll);
            check("q_rl", q_rl, e_rl);
            check("q_ra", q_ra, e_ra);
            check("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
`ifdef SHIFTER32_ROTATE_EN
            check("y_rotl", y_rotl, m_rotl(a, int'(s)));
            check("y_rotr", y_rotr, m_rotr(a, int'(s)));
            check("q_rotl", q_rotl, e_rotl);
            check("q_rotr", q_rotr, e_rotr);
`endif
        end
    end

    logic [31:0] va [4] = '{32'h8000_0001, 32'h8000_0001, 32'hF0F0_1234, 32'h7FFF_FFFF};
    logic [4:0]  vs [4] = '{5'd0, 5'd1, 5'd31, 5'd4};
    logic [31:0] vll[4] = '{32'h8000_0001, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFF0};
    logic [31:0] vrl[4] = '{32'h8000_0001, 32'h4000_0000, 32'h0000_0001, 32'h07FF_FFFF};
    logic [31:0] vra[4] = '{32'h8000_0001, 32'hC000_0000, 32'hFFFF_FFFF, 32'h07FF_FFFF};

    initial begin
        rst_n = 1'b1; a = '0; s = '0; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst q_ll", q_ll, 32'h0);
        check("rst q_ra", q_ra, 32'h0);
        check("rst out_valid", {31'd0, out_valid}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1; chk_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 a = va[i]; s = vs[i];
            #1;
            check("lit y_ll", y_ll, vll[i]);
            check("lit y_rl", y_rl, vrl[i]);
            check("lit y_ra", y_ra, vra[i]);
        end

        @(posedge clk); #1 a = 32'h8000_0000; s = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; a = 32'h0000_FFFF; s = 5'd7;
        check("reg q_ra", q_ra, 32'hF000_0000);
        check("reg q_rl", q_rl, 32'h1000_0000);
        check("reg q_ll", q_ll, 32'h0);
        check("reg out_valid", {31'd0, out_valid}, 32'h1);
        @(posedge clk); #1;
        check("hold out_valid", {31'd0, out_valid}, 32'h0);
        check("hold q_ra", q_ra, 32'hF000_0000);

        a = 32'hDEAD_BEEF; s = 5'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        check("pre-rst q_rl", q_rl, 32'h0DEA_DBEE);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst q_ll", q_ll, 32'h0);
        check("mid rst q_rl", q_rl, 32'h0);
        check("mid rst q_ra", q_ra, 32'h0);
        check("mid rst out_valid", {31'd0, out_valid}, 32'h0);
        check("rst comb y_ra", y_ra, 32'hFDEA_DBEE);
        @(posedge clk); #1;
        check("in rst out_valid", {31'd0, out_valid}, 32'h0);
        rst_n = 1'b1; a = 32'h1234_5678; s = 5'd8;
        @(posedge clk); #1;
        check("rel q_rl", q_rl, 32'h0012_3456);
        check("rel out_valid", {31'd0, out_valid}, 32'h1);

`ifdef SHIFTER32_ROTATE_EN
        a = 32'h8000_0001; s = 5'd1; in_valid = 1'b0;
        #1;
        check("lit y_rotl", y_rotl, 32'h0000_0003);
        check("lit y_rotr", y_rotr, 32'hC000_0000);
`endif

        for (int i = 0; i < 1024; i++) begin
            @(posedge clk); #1;
            a = $urandom;
            s = 5'($urandom_range(0, 31));
            in_valid = 1'($urandom_range(0, 1));
        end

        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
